// File: rtl/timer_bamse.sv
// timer_bamse: port-mapped 16-bit up-counting timer with 3-bit prescaler,
// single-shot / auto-reload modes and a sticky rollover interrupt flag.
module timer_bamse #(
    parameter logic [7:0] ADDR = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] timer_conf,
    input  logic [7:0]  address,
    input  logic [7:0]  config_in,
    output logic [7:0]  config_out,
    input  logic        ren,
    input  logic        wen
);

    logic [2:0]  r_presc;
    logic        r_auto_load;
    logic        r_en;
    logic        r_running;
    logic        r_irq_flag;
    logic [15:0] r_count;
    logic [2:0]  r_pcnt;

    logic w_write;
    logic w_load;
    logic w_active;
    logic w_tick;
    logic w_rollover;
    logic w_unused;

    assign w_write    = wen && (address == ADDR);
    assign w_load     = config_in[2] && config_in[1];
    assign w_active   = r_running && r_en;
    assign w_tick     = w_active && (r_pcnt == r_presc);
    assign w_rollover = w_tick && (r_count == 16'hFFFF);

    // Reads are side-effect free and bit 7 of the write data is reserved.
    assign w_unused = ren ^ config_in[7];

    assign config_out = {1'b0, r_presc, r_auto_load, r_en, r_running, r_irq_flag};

    // Configuration fields latched by an accepted write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= 3'd0;
            r_auto_load <= 1'b0;
            r_en        <= 1'b0;
        end else if (w_write) begin
            r_presc     <= config_in[6:4];
            r_auto_load <= config_in[3];
            r_en        <= config_in[2];
        end else begin
            r_presc     <= r_presc;
            r_auto_load <= r_auto_load;
            r_en        <= r_en;
        end
    end

    // Prescaler, counter and run state; a write overrides a same-edge tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= 16'd0;
            r_pcnt    <= 3'd0;
            r_running <= 1'b0;
        end else if (w_write) begin
            r_pcnt <= 3'd0;
            if (w_load) begin
                r_count   <= timer_conf;
                r_running <= 1'b1;
            end else begin
                r_count   <= r_count;
                r_running <= 1'b0;
            end
        end else if (w_tick) begin
            r_pcnt <= 3'd0;
            if (w_rollover) begin
                r_count   <= timer_conf;
                r_running <= r_auto_load;
            end else begin
                r_count   <= r_count + 16'd1;
                r_running <= r_running;
            end
        end else if (w_active) begin
            r_pcnt    <= r_pcnt + 3'd1;
            r_count   <= r_count;
            r_running <= r_running;
        end else begin
            r_pcnt    <= r_pcnt;
            r_count   <= r_count;
            r_running <= r_running;
        end
    end

    // Sticky interrupt: a rollover beats a clearing write on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_flag <= 1'b0;
        end else if (w_rollover) begin
            r_irq_flag <= 1'b1;
        end else if (w_write && !config_in[0]) begin
            r_irq_flag <= 1'b0;
        end else begin
            r_irq_flag <= r_irq_flag;
        end
    end

endmodule

// File: tb/tb_timer_bamse.sv
// Scoreboard bench for timer_bamse: an event-time reference model predicts
// config_out for every clock edge; a monitor compares the DUT against it.
module tb_timer_bamse;

    logic        clk;
    logic        rst;
    logic [15:0] timer_conf;
    logic [7:0]  address;
    logic [7:0]  config_in;
    logic [7:0]  config_out;
    logic        ren;
    logic        wen;

    timer_bamse #(.ADDR(8'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_conf (timer_conf),
        .address    (address),
        .config_in  (config_in),
        .config_out (config_out),
        .ren        (ren),
        .wen        (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       done_s = 1'b0;

    // Reference model: abstract state plus the absolute edge index of the
    // next rollover, computed as (0x10000 - conf) * (presc + 1) clocks ahead.
    int         cyc = 0;
    logic [2:0] m_presc;
    logic       m_auto;
    logic       m_en;
    logic       m_running;
    logic       m_irq;
    int         m_next_roll;

    function automatic logic [7:0] m_status();
        return {1'b0, m_presc, m_auto, m_en, m_running, m_irq};
    endfunction

    task automatic m_clear();
        m_presc     = 3'd0;
        m_auto      = 1'b0;
        m_en        = 1'b0;
        m_running   = 1'b0;
        m_irq       = 1'b0;
        m_next_roll = -1;
    endtask

    // One clock: drive inputs, predict the state after the next rising edge.
    task automatic step(input logic w, input logic [7:0] a, input logic [7:0] c,
                        input logic [15:0] tc);
        logic wr;
        logic roll;
        @(negedge clk);
        rst        = 1'b1;
        wen        = w;
        address    = a;
        config_in  = c;
        timer_conf = tc;
        ren        = 1'($urandom_range(0, 1));
        cyc++;
        wr   = w && (a == 8'h01);
        roll = m_running && (cyc == m_next_roll);
        if (roll) begin
            m_irq = 1'b1;
            if (!wr) begin
                m_running = m_auto;
                if (m_auto)
                    m_next_roll = cyc + (32'd65536 - 32'(tc)) * (32'(m_presc) + 32'd1);
            end
        end
        if (wr) begin
            m_presc = c[6:4];
            m_auto  = c[3];
            m_en    = c[2];
            if (!roll && !c[0])
                m_irq = 1'b0;
            if (c[2] && c[1]) begin
                m_running   = 1'b1;
                m_next_roll = cyc + (32'd65536 - 32'(tc)) * (32'(c[6:4]) + 32'd1);
            end else begin
                m_running = 1'b0;
            end
        end
        exp_q.push_back(m_status());
    endtask

    task automatic idle(input int n, input logic [15:0] tc);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'($urandom_range(0, 3)), 8'($urandom), tc);
    endtask

    // Asynchronous reset mid-cycle: status must read zero at once and on the next edge.
    task automatic do_reset();
        @(negedge clk);
        wen = 1'b0;
        m_clear();
        exp_q.push_back(8'h00);
        rst = 1'b0;
        exp_q.push_back(8'h00);
        cyc++;
    endtask

    // Monitor: one expectation per rising edge or reset assertion.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (config_out !== e) begin
                    n_bad++;
                    $display("FAIL config_out edge=%0d got=%02h want=%02h", cyc, config_out, e);
                end
            end
        end
    end

    // Watchdog: the stimulus must complete before the time limit expires.
    initial begin
        #5000000;
        n_cmp++;
        if (done_s !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not complete");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        logic [15:0] tc;
        logic [7:0]  cfg;
        logic [7:0]  adr;
        rst        = 1'b0;
        wen        = 1'b0;
        ren        = 1'b0;
        address    = 8'h00;
        config_in  = 8'h00;
        timer_conf = 16'hFFF0;
        m_clear();
        exp_q.push_back(8'h00);
        cyc = 1;
        #2;
        n_cmp++;
        if (config_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset state config_out got=%02h want=00", config_out);
        end

        idle(2, 16'hFFF0);
        step(1'b1, 8'h01, 8'h06, 16'hFFF0);
        idle(20, 16'hFFF0);
        step(1'b1, 8'h01, 8'h36, 16'hFFF0);
        idle(70, 16'hFFF0);
        step(1'b1, 8'h01, 8'h0E, 16'hFFF0);
        idle(40, 16'hFFF0);
        step(1'b1, 8'h01, 8'h0C, 16'hFFF0);
        idle(40, 16'hFFF0);
        step(1'b1, 8'h01, 8'h0E, 16'hFFF0);
        idle(20, 16'hFFF0);
        step(1'b1, 8'h01, 8'h08, 16'hFFF0);
        idle(20, 16'hFFF0);
        step(1'b1, 8'h01, 8'h0E, 16'hFFF0);
        idle(20, 16'hFFF0);
        step(1'b1, 8'h02, 8'h00, 16'hFFF0);
        idle(5, 16'hFFF0);
        step(1'b1, 8'h01, 8'h06, 16'hFFF0);
        idle(15, 16'hFFF0);
        step(1'b1, 8'h01, 8'h06, 16'hFFF0);
        idle(20, 16'hFFF0);
        step(1'b1, 8'h01, 8'h0E, 16'hFFF0);
        idle(5, 16'hFFF0);
        do_reset();
        idle(5, 16'hFFF0);

        for (int op = 0; op < 60; op++) begin
            tc  = 16'hFFFF - 16'($urandom_range(0, 31));
            cfg = 8'($urandom);
            if ($urandom_range(0, 3) != 0)
                cfg[2:1] = 2'b11;
            adr = ($urandom_range(0, 7) == 0) ? 8'h02 : 8'h01;
            step(1'b1, adr, cfg, tc);
            idle($urandom_range(0, 150), tc);
            if ($urandom_range(0, 3) == 0)
                tc = 16'hFFFF - 16'($urandom_range(0, 31));
            idle($urandom_range(0, 150), tc);
            if ($urandom_range(0, 15) == 0)
                do_reset();
        end

        @(posedge clk);
        #2;
        done_s = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
